// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decryptor: walks the key-scheduled S-box, swaps
// entries and XORs each keystream byte with a ciphertext ROM byte into a plaintext RAM.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_wren
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_SI   = 4'd1,
    ST_WAIT_SI = 4'd2,
    ST_RD_SJ   = 4'd3,
    ST_WAIT_SJ = 4'd4,
    ST_WR_SI   = 4'd5,
    ST_WR_SJ   = 4'd6,
    ST_RD_F    = 4'd7,
    ST_WAIT_F  = 4'd8,
    ST_WR_OUT  = 4'd9,
    ST_DONE    = 4'd10
  } state_t;

  localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

  state_t            state_r, state_s;
  logic [7:0]        i_r, i_s;
  logic [7:0]        j_r, j_s;
  logic [7:0]        si_r, si_s;
  logic [7:0]        sj_r, sj_s;
  logic [MSG_AW-1:0] k_r, k_s;

  logic              finish_s;
  logic [7:0]        s_address_s;
  logic [7:0]        s_data_s;
  logic              s_wren_s;
  logic [MSG_AW-1:0] rom_address_s;
  logic [MSG_AW-1:0] ram_address_s;
  logic [7:0]        ram_data_s;
  logic              ram_wren_s;

  // Next-state and index/datapath update for the nine-cycle per-byte sequence.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    si_s    = si_r;
    sj_s    = sj_r;
    k_s     = k_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          i_s     = 8'd1;
          j_s     = 8'd0;
          k_s     = {MSG_AW{1'b0}};
          state_s = ST_RD_SI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_SI:   state_s = ST_WAIT_SI;
      ST_WAIT_SI: begin
        si_s    = s_q;
        state_s = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        j_s     = j_r + si_r;
        state_s = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: begin
        sj_s    = s_q;
        state_s = ST_WR_SI;
      end
      ST_WR_SI:   state_s = ST_WR_SJ;
      ST_WR_SJ:   state_s = ST_RD_F;
      ST_RD_F:    state_s = ST_WAIT_F;
      ST_WAIT_F:  state_s = ST_WR_OUT;
      ST_WR_OUT: begin
        if (k_r == LAST_K) begin
          state_s = ST_DONE;
        end else begin
          k_s     = k_r + MSG_AW'(1);
          i_s     = i_r + 8'd1;
          state_s = ST_RD_SI;
        end
      end
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is registered yet
  // visible during the state it belongs to; keystream and ciphertext are
  // folded straight into the plaintext register while leaving WAIT_F.
  always_comb begin
    finish_s      = 1'b0;
    s_address_s   = 8'd0;
    s_data_s      = 8'd0;
    s_wren_s      = 1'b0;
    rom_address_s = {MSG_AW{1'b0}};
    ram_address_s = {MSG_AW{1'b0}};
    ram_data_s    = 8'd0;
    ram_wren_s    = 1'b0;
    case (state_s)
      ST_RD_SI: s_address_s = i_s;
      ST_RD_SJ: s_address_s = j_s + si_s;
      ST_WR_SI: begin
        s_address_s = i_s;
        s_data_s    = sj_s;
        s_wren_s    = 1'b1;
      end
      ST_WR_SJ: begin
        s_address_s = j_s;
        s_data_s    = si_s;
        s_wren_s    = 1'b1;
      end
      ST_RD_F: begin
        s_address_s   = si_s + sj_s;
        rom_address_s = k_s;
      end
      ST_WR_OUT: begin
        ram_address_s = k_s;
        ram_data_s    = s_q ^ rom_q;
        ram_wren_s    = 1'b1;
      end
      ST_DONE:  finish_s = 1'b1;
      default:  finish_s = 1'b0;
    endcase
  end

  // State, index and output registers; reset clears everything so the
  // write enables drop immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      i_r         <= 8'd0;
      j_r         <= 8'd0;
      si_r        <= 8'd0;
      sj_r        <= 8'd0;
      k_r         <= {MSG_AW{1'b0}};
      finish      <= 1'b0;
      s_address   <= 8'd0;
      s_data      <= 8'd0;
      s_wren      <= 1'b0;
      rom_address <= {MSG_AW{1'b0}};
      ram_address <= {MSG_AW{1'b0}};
      ram_data    <= 8'd0;
      ram_wren    <= 1'b0;
    end else begin
      state_r     <= state_s;
      i_r         <= i_s;
      j_r         <= j_s;
      si_r        <= si_s;
      sj_r        <= sj_s;
      k_r         <= k_s;
      finish      <= finish_s;
      s_address   <= s_address_s;
      s_data      <= s_data_s;
      s_wren      <= s_wren_s;
      rom_address <= rom_address_s;
      ram_address <= ram_address_s;
      ram_data    <= ram_data_s;
      ram_wren    <= ram_wren_s;
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: a 32-byte and a 256-byte instance with behavioural
// memories, a reference RC4 model feeding a scoreboard, and timing counters.
module tb_rc4_prga_decrypt;

  logic clock, reset, start_req, sel, ld_req;
  logic start32, start256;

  logic       fin32, sw32, ramw32;
  logic [7:0] sa32, sd32, sq32, romq32, ramd32;
  logic [4:0] roma32, rama32;

  logic       fin256, sw256, ramw256;
  logic [7:0] sa256, sd256, sq256, romq256, ramd256;
  logic [7:0] roma256, rama256;

  logic [7:0] s32 [256];
  logic [7:0] s256 [256];
  logic [7:0] s_init [256];
  logic [7:0] s_model [256];
  logic [7:0] rom32 [32];
  logic [7:0] rom256 [256];
  logic [7:0] ram32 [32];
  logic [7:0] ram256 [256];
  logic [7:0] sa32_r, sa256_r, roma256_r;
  logic [4:0] roma32_r;

  logic [15:0] exp_q [$];
  int n_checks, n_fails;

  assign start32  = start_req & ~sel;
  assign start256 = start_req & sel;

  rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .finish(fin32),
    .s_address(sa32), .s_data(sd32), .s_wren(sw32), .s_q(sq32),
    .rom_address(roma32), .rom_q(romq32),
    .ram_address(rama32), .ram_data(ramd32), .ram_wren(ramw32)
  );

  rc4_prga_decrypt #(.MSG_LEN(256), .MSG_AW(8)) dut256 (
    .clock(clock), .reset(reset), .start(start256), .finish(fin256),
    .s_address(sa256), .s_data(sd256), .s_wren(sw256), .s_q(sq256),
    .rom_address(roma256), .rom_q(romq256),
    .ram_address(rama256), .ram_data(ramd256), .ram_wren(ramw256)
  );

  // Memories with registered addresses; ld_req reloads S and clears the RAMs.
  always @(posedge clock) begin
    if (ld_req) begin
      s32    <= s_init;
      s256   <= s_init;
      ram32  <= '{default: 8'h00};
      ram256 <= '{default: 8'h00};
    end else begin
      if (sw32)    s32[sa32]       <= sd32;
      if (sw256)   s256[sa256]     <= sd256;
      if (ramw32)  ram32[rama32]   <= ramd32;
      if (ramw256) ram256[rama256] <= ramd256;
    end
    sa32_r    <= sa32;
    roma32_r  <= roma32;
    sa256_r   <= sa256;
    roma256_r <= roma256;
  end

  assign sq32    = s32[sa32_r];
  assign romq32  = rom32[roma32_r];
  assign sq256   = s256[sa256_r];
  assign romq256 = rom256[roma256_r];

  logic       fin_m, sw_m, rw_m;
  logic [7:0] rama_m, ramd_m;
  assign fin_m  = sel ? fin256  : fin32;
  assign sw_m   = sel ? sw256   : sw32;
  assign rw_m   = sel ? ramw256 : ramw32;
  assign rama_m = sel ? rama256 : {3'b000, rama32};
  assign ramd_m = sel ? ramd256 : ramd32;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_s();
    @(negedge clock);
    ld_req = 1'b1;
    @(negedge clock);
    ld_req = 1'b0;
  endtask

  // Textbook RC4 PRGA over a copy of s_init; pushes {k, plaintext} per byte.
  task automatic build_model(input bit sel_in, input int n);
    logic [7:0] sm [256];
    logic [7:0] i, j, t, f, ct, idx;
    sm = s_init;
    i  = 8'd0;
    j  = 8'd0;
    for (int k = 0; k < n; k++) begin
      i     = i + 8'd1;
      j     = j + sm[i];
      t     = sm[i];
      sm[i] = sm[j];
      sm[j] = t;
      idx   = sm[i] + sm[j];
      f     = sm[idx];
      ct    = sel_in ? rom256[k[7:0]] : rom32[k[4:0]];
      exp_q.push_back({k[7:0], f ^ ct});
    end
    s_model = sm;
  endtask

  task automatic run_msg(input bit sel_in, input int abort_at, input int extra_at,
                         output int fin_cyc, output int fin_cnt, output int sw_cnt, output int rw_cnt);
    int cyc;
    int budget;
    logic [15:0] e;
    sel     = sel_in;
    fin_cyc = 0;
    fin_cnt = 0;
    sw_cnt  = 0;
    rw_cnt  = 0;
    cyc     = 0;
    budget  = sel_in ? 2400 : 400;
    @(negedge clock);
    start_req = 1'b1;
    while (cyc < budget && !(fin_cnt > 0 && cyc > fin_cyc)) begin
      @(negedge clock);
      cyc++;
      start_req = (cyc == extra_at) ? 1'b1 : 1'b0;
      if (sw_m) sw_cnt++;
      if (rw_m) begin
        rw_cnt++;
        check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("ram_addr", 32'(rama_m), 32'(e[15:8]));
          check_val("ram_data", 32'(ramd_m), 32'(e[7:0]));
        end
      end
      if (fin_m) begin
        fin_cnt++;
        if (fin_cyc == 0) fin_cyc = cyc;
      end
      if (cyc == abort_at) begin
        reset = 1'b1;
        #1;
        check_val("abort_s_wren", 32'(sw_m), 32'd0);
        check_val("abort_ram_wren", 32'(rw_m), 32'd0);
        check_val("abort_finish", 32'(fin_m), 32'd0);
        break;
      end
    end
    start_req = 1'b0;
  endtask

  task automatic check_s(input bit sel_in);
    for (int a = 0; a < 256; a++) begin
      check_val("s_final", 32'(sel_in ? s256[a] : s32[a]), 32'(s_model[a]));
    end
  endtask

  int fc, fn, swc, rwc;
  logic [7:0] tmp;
  int r;

  initial begin
    reset = 1'b0; start_req = 1'b0; sel = 1'b0; ld_req = 1'b0;
    n_checks = 0; n_fails = 0;
    for (int a = 0; a < 32; a++) rom32[a] = 8'h00;
    for (int a = 0; a < 256; a++) begin
      rom256[a] = 8'h00;
      s_init[a] = 8'(a);
    end

    // Reset before any clock edge
    #1 reset = 1'b1;
    #1;
    check_val("rst_finish", 32'(fin32), 32'd0);
    check_val("rst_s_address", 32'(sa32), 32'd0);
    check_val("rst_s_data", 32'(sd32), 32'd0);
    check_val("rst_s_wren", 32'(sw32), 32'd0);
    check_val("rst_rom_address", 32'(roma32), 32'd0);
    check_val("rst_ram_address", 32'(rama32), 32'd0);
    check_val("rst_ram_data", 32'(ramd32), 32'd0);
    check_val("rst_ram_wren", 32'(ramw32), 32'd0);
    check_val("rst_finish_256", 32'(fin256), 32'd0);
    check_val("rst_s_wren_256", 32'(sw256), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Identity S, zero ciphertext; also the timing/count run
    load_s();
    build_model(1'b0, 32);
    run_msg(1'b0, 0, 0, fc, fn, swc, rwc);
    check_val("id_ram0", 32'(ram32[0]), 32'h02);
    check_val("id_ram1", 32'(ram32[1]), 32'h05);
    check_val("id_ram2", 32'(ram32[2]), 32'h07);
    check_val("finish_cycle", 32'(fc), 32'd289);
    check_val("finish_width", 32'(fn), 32'd1);
    check_val("s_wren_cycles", 32'(swc), 32'd64);
    check_val("ram_wren_cycles", 32'(rwc), 32'd32);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    check_s(1'b0);

    // Identity S, ciphertext 0xAF
    for (int a = 0; a < 32; a++) rom32[a] = 8'hAF;
    load_s();
    build_model(1'b0, 32);
    run_msg(1'b0, 0, 0, fc, fn, swc, rwc);
    check_val("af_ram0", 32'(ram32[0]), 32'hAD);
    check_val("af_ram1", 32'(ram32[1]), 32'hAA);
    check_val("af_ram2", 32'(ram32[2]), 32'hA8);
    check_val("af_finish_cycle", 32'(fc), 32'd289);

    // Abort at cycle 100, reload, rerun with an ignored start at cycle 50
    for (int a = 0; a < 32; a++) rom32[a] = 8'h00;
    load_s();
    build_model(1'b0, 32);
    run_msg(1'b0, 100, 0, fc, fn, swc, rwc);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    load_s();
    build_model(1'b0, 32);
    run_msg(1'b0, 0, 50, fc, fn, swc, rwc);
    check_val("rerun_finish_cycle", 32'(fc), 32'd289);
    check_val("rerun_finish_width", 32'(fn), 32'd1);
    check_val("rerun_ram0", 32'(ram32[0]), 32'h02);
    check_val("rerun_ram_wren_cycles", 32'(rwc), 32'd32);
    check_val("rerun_sb_drained", 32'(exp_q.size()), 32'd0);
    check_s(1'b0);

    // 256 bytes, random S permutation and random ciphertext
    for (int a = 255; a > 0; a--) begin
      r = int'($urandom_range(a, 0));
      tmp = s_init[a];
      s_init[a] = s_init[r];
      s_init[r] = tmp;
    end
    for (int a = 0; a < 256; a++) rom256[a] = 8'($urandom_range(255, 0));
    load_s();
    build_model(1'b1, 256);
    run_msg(1'b1, 0, 0, fc, fn, swc, rwc);
    check_val("long_finish_cycle", 32'(fc), 32'd2305);
    check_val("long_finish_width", 32'(fn), 32'd1);
    check_val("long_s_wren_cycles", 32'(swc), 32'd512);
    check_val("long_ram_wren_cycles", 32'(rwc), 32'd256);
    check_val("long_sb_drained", 32'(exp_q.size()), 32'd0);
    check_s(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
